// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory responder.
// Holds the FSM state encoding and the word/lane geometry.
package dmem_pkg;

  localparam int WORD_W = 32;
  localparam int LANES  = 4;

  localparam logic [LANES-1:0] WEN_READ = 4'b0000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } dmem_state_e;

endpackage

// File: rtl/dmem_if.sv
// dmem_if: CPU data-memory request/response bundle.
// master = MEM-stage translator, slave = memory responder.
interface dmem_if;
  import dmem_pkg::*;

  logic              mem_en;
  logic [LANES-1:0]  mem_wen;
  logic [31:0]       mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic [WORD_W-1:0] mem_rdata;
  logic              mem_rdy;
  logic              mem_stall;

  modport master (
    output mem_en,
    output mem_wen,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_rdy,
    input  mem_stall
  );

  modport slave (
    input  mem_en,
    input  mem_wen,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_rdy,
    output mem_stall
  );

endinterface

// File: rtl/dmem_ram.sv
// dmem_ram: single-port synchronous word RAM, byte write enables,
// one-cycle read latency, read-old-data on write.
module dmem_ram
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              en,
  input  logic [LANES-1:0]  we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < LANES; i++) begin
        if (we[i]) begin
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: one-at-a-time data-memory responder with stall/ready.
// Define DMEM_WAIT_EN to insert WAIT_CYCLES wait states per access.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic   clk,
  input  logic   rst,
  dmem_if.slave  bus
);

  logic [1:0]        state_q;
  logic [1:0]        state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [LANES-1:0]  wen_q;
  logic [WORD_W-1:0] wdata_q;
  logic [WORD_W-1:0] hold_q;
  logic [WORD_W-1:0] ram_q;
  logic [WORD_W-1:0] rdata;
  logic              accept;
  logic              unused_ok;

`ifdef DMEM_WAIT_EN
  logic [3:0] cnt_q;
`endif

  assign accept = (state_q == IDLE) && bus.mem_en;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.mem_en) begin
`ifdef DMEM_WAIT_EN
          state_d = (WAIT_CYCLES > 0) ? WAIT : ACCESS;
`else
          state_d = ACCESS;
`endif
        end
      end
`ifdef DMEM_WAIT_EN
      WAIT:    if (cnt_q == 4'd0) state_d = ACCESS;
`else
      WAIT:    state_d = IDLE;
`endif
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef DMEM_WAIT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 4'd0;
    end else if (accept) begin
      cnt_q <= (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    end else if (state_q == WAIT && cnt_q != 4'd0) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wen_q   <= WEN_READ;
      wdata_q <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= bus.mem_addr[ADDR_W+1:2];
        wen_q   <= bus.mem_wen;
        wdata_q <= bus.mem_wdata;
      end
      if (state_q == RESP) hold_q <= rdata;
    end
  end

  dmem_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .en    (state_q == ACCESS),
    .we    (wen_q),
    .addr  (addr_q),
    .wdata (wdata_q),
    .rdata (ram_q)
  );

  // RAM output is already a flop; in RESP it is the response,
  // afterwards the captured copy keeps the port stable.
  assign rdata         = (wen_q == WEN_READ) ? ram_q : '0;
  assign bus.mem_rdata = (state_q == RESP) ? rdata : hold_q;
  assign bus.mem_rdy   = (state_q == RESP);
  assign bus.mem_stall = (state_q == IDLE) ? (bus.mem_en && !rst)
                                           : (state_q != RESP);

  assign unused_ok = ^{bus.mem_addr[31:ADDR_W+2], bus.mem_addr[1:0],
                       4'(WAIT_CYCLES)};

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the CPU data-memory port: accepts one enable/byte-write-enable/address/write-data request at a time from the MEM-stage load/store translator, applies the byte-lane write or full-word read to a local word RAM after a programmable number of wait states, and returns the raw 32-bit word with a one-cycle ready pulse. It holds the pipeline with a stall signal while a request is in flight. Lane extraction and sign extension stay on the CPU side; this block never interprets the opcode.

## Interface
- `ADDR_W`, default 10: word-address width; RAM depth = 2^ADDR_W words.
- `WAIT_CYCLES`, default 2: wait states inserted per access (used only with `DMEM_WAIT_EN`); range 0–15.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `mem_en`  in  1  request valid (already suppressed on address errors by the CPU).
- `mem_wen`  in  4  byte-lane write enables; lane i = bits [8i+7:8i]; 4'b0000 = read.
- `mem_addr`  in  32  byte address; bits [ADDR_W+1:2] index the RAM, others ignored.
- `mem_wdata`  in  32  write data, already lane-replicated by the CPU.
- `mem_rdata`  out  32  read word, valid only while `mem_rdy` = 1.
- `mem_rdy`  out  1  one-cycle completion pulse.
- `mem_stall`  out  1  pipeline hold.

## Operation
- FSM states: IDLE, WAIT, ACCESS, RESP.
- IDLE: if `mem_en`=1, latch addr/wen/wdata; go to WAIT if `DMEM_WAIT_EN` and WAIT_CYCLES>0 (load counter = WAIT_CYCLES−1), otherwise go to ACCESS.
- WAIT: decrement counter; at 0 go to ACCESS. Inputs are ignored; latched values are used.
- ACCESS: RAM cycle on the latched word index. If any wen bit is set, write the enabled lanes only. Otherwise read the word.
- RESP: `mem_rdy`=1. `mem_rdata` = RAM word for reads and 32'h0 for writes. Go to IDLE unconditionally.
- `mem_en` during RESP is ignored: it is the same, completing instruction. A new request is accepted only in IDLE.
- Address aliasing: addresses wrap modulo 2^ADDR_W words. There is no error output. Byte offset bits [1:0] are ignored.
- Reset mid-operation: the FSM returns to IDLE. A latched write that has not yet reached ACCESS is discarded. RAM contents are not cleared.
- Reset values: state IDLE, counter 0, `mem_rdy` 0, `mem_rdata` 32'h0, latched registers 0.

## Timing
- `mem_stall` = (state≠IDLE && state≠RESP) || (state==IDLE && `mem_en`). This is combinational from `mem_en` in IDLE, which freezes the pipeline in the request cycle.
- Latency with wait states: request accepted in cycle 0; WAIT occupies cycles 1..W; ACCESS in cycle W+1; RESP in cycle W+2.
- Latency without wait states: ACCESS in cycle 1, RESP in cycle 2.
- Stall is high from cycle 0 through the ACCESS cycle. It is low in RESP, so the CPU advances at the end of RESP.
- Back-to-back accesses: a new request is accepted at the earliest one cycle after RESP. Throughput is one access per W+3 cycles.
- `mem_rdata` is registered. It holds its last value outside RESP, but is defined only while `mem_rdy`=1.

## Configuration
- `DMEM_WAIT_EN` defined: the WAIT state and the counter exist, and WAIT_CYCLES is honoured.
- `DMEM_WAIT_EN` undefined: the WAIT state and the counter are compiled out and WAIT_CYCLES is ignored. This gives a fixed 2-cycle latency, and the FSM is IDLE→ACCESS→RESP.
- With the macro defined, WAIT_CYCLES=0 gives behaviour identical to the macro undefined.

## Structure
- Package `dmem_pkg`: state enum (IDLE, WAIT, ACCESS, RESP), `WORD_W`=32, `LANES`=4, and the constant `WEN_READ`=4'b0000.
- Sub-module `dmem_ram`: single-port synchronous RAM with 2^ADDR_W×32 words and per-byte write enables. It has a 1-cycle read latency and read-old-data on write.
- `dmem_responder` holds the FSM, wait counter, request latches and output registers.

## Test plan
- Reset then idle: rst high for 2 cycles with `mem_en`=1. Required: `mem_stall`=1 only after rst drops; `mem_rdy`=0 and `mem_rdata`=0 throughout reset.
- Full-word write then read, W=2: write 32'hDEADBEEF with wen=4'b1111 to addr 0x10. Required: `mem_rdy` at cycle 4 and `mem_rdata`=0. Then read 0x10. Required: `mem_rdy` at cycle 4 and `mem_rdata`=32'hDEADBEEF; stall high for exactly 4 cycles of each access.
- Byte-lane write: preload 0x20 with 32'h11223344, then write wdata 32'hAAAAAAAA with wen=4'b0100. Required: reading 0x20 returns 32'h11AA3344.
- Halfword write: write wdata 32'h55665566 with wen=4'b1100 to 0x20. Required: reading returns 32'h55663344.
- Aliasing: with ADDR_W=10, write 32'h01234567 to 0x1004. Required: a read of 0x0004 returns 32'h01234567.
- Reset mid-operation: assert rst during WAIT of a write of 32'hFFFFFFFF to 0x30 that had 32'h0 stored. Required: FSM back in IDLE and a later read of 0x30 returns 32'h0. With the macro undefined: every access has `mem_rdy` in cycle 2.
